interrupt_sequencer: RTL

- Owns the CPU bus while servicing reset, NMI, IRQ and BRK.
- At an instruction boundary it stalls the control unit via `busy` and pushes PCH, PCL and P to the stack page. It then fetches the 16-bit vector and loads it into PC.
- Sits beside control_unit and shares the address, data and read/write paths through a top-level mux keyed on `busy`.

---
 rtl/interrupt_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: takes the bus at an instruction boundary to push PC/P and
// load the reset, NMI, IRQ or BRK vector into PC.
module interrupt_sequencer #(
  parameter logic [7:0]  STACK_PAGE   = 8'h01,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk,
  input  logic        boundary,
  input  logic        i_flag,
  input  logic [7:0]  status_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] address,
  output logic [7:0]  data_out,
  output logic        read_write,
  output logic        sp_dec,
  output logic        i_set,
  output logic        pc_load,
  output logic [15:0] pc_value,
  output logic [2:0]  fsm
);
  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_L, VEC_H, RST_VL, RST_VH} state_e;
  typedef enum logic [1:0] {SRC_NMI, SRC_IRQ, SRC_BRK} src_e;
  state_e      state_q;
  src_e        src_q;
  logic        nmi_pending_q, nmi_prev_q;
  logic [7:0]  vec_lo_q;
  logic        take_irq, nmi_clr, pushing, vec_lo_st, vec_hi_st;
  logic [15:0] vec_base;
  assign take_irq = ~irq_n & ~i_flag;
  // a pending NMI is consumed either at a boundary or by hijacking an IRQ/BRK push
  assign nmi_clr = nmi_pending_q & ((state_q == IDLE & boundary) | (state_q == PUSH_P & src_q != SRC_NMI));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RST_VL;
      src_q         <= SRC_IRQ;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b1;
      vec_lo_q      <= 8'h00;
    end else begin
      nmi_prev_q    <= nmi_n;
      nmi_pending_q <= (nmi_prev_q & ~nmi_n) | (nmi_pending_q & ~nmi_clr);
      case (state_q)
        IDLE:
          if (boundary && (nmi_pending_q || take_irq || brk)) begin
            state_q <= PUSH_PCH;
            src_q   <= nmi_pending_q ? SRC_NMI : take_irq ? SRC_IRQ : SRC_BRK;
          end
        PUSH_PCH: state_q <= PUSH_PCL;
        PUSH_PCL: state_q <= PUSH_P;
        PUSH_P: begin
          state_q <= VEC_L;
          if (nmi_clr) src_q <= SRC_NMI;
        end
        VEC_L: begin
          state_q  <= VEC_H;
          vec_lo_q <= data_in;
        end
        VEC_H: state_q <= IDLE;
        RST_VL: begin
          state_q  <= RST_VH;
          vec_lo_q <= data_in;
        end
        RST_VH: state_q <= IDLE;
      endcase
    end
  end
  assign pushing   = state_q inside {PUSH_PCH, PUSH_PCL, PUSH_P};
  assign vec_lo_st = state_q inside {VEC_L, RST_VL};
  assign vec_hi_st = state_q inside {VEC_H, RST_VH};
  assign vec_base  = state_q inside {RST_VL, RST_VH} ? RESET_VECTOR :
                     src_q == SRC_NMI ? NMI_VECTOR : IRQ_VECTOR;
  assign busy       = state_q != IDLE;
  assign read_write = pushing;
  assign sp_dec     = pushing;
  assign i_set      = vec_lo_st;
  assign pc_load    = vec_hi_st;
  assign fsm        = state_q;
  assign address    = pushing ? {STACK_PAGE, sp_in} : vec_lo_st ? vec_base :
                      vec_hi_st ? vec_base + 16'd1 : 16'h0000;
  // pushed P always has bit5 set; B (bit4) marks a software BRK
  assign data_out   = state_q == PUSH_PCH ? pc_in[15:8] :
                      state_q == PUSH_PCL ? pc_in[7:0] :
                      state_q == PUSH_P ? {status_in[7:6], 1'b1, src_q == SRC_BRK, status_in[3:0]} : 8'h00;
  assign pc_value   = vec_hi_st ? {data_in, vec_lo_q} : 16'h0000;
endmodule
